source_frame_arbiter: RTL and testbench

- Shares one network_source command port (src / src_valid / src_ready) between NUM_REQ independent command streams, e.g. the host link and an on-chip stimulus generator.
- Grants the port to one requester for a whole frame, so SPK/SPK_PRDC commands from different requesters never interleave ahead of a RUN.
- A frame is any command sequence terminated by a RUN or CLR handshake. Round-robin fairness applies between frames.

---
 rtl/source_frame_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_source_frame_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/source_frame_arbiter.sv
// source_frame_arbiter
//   Shares one network_source command port between NUM_REQ independent command
//   streams. A requester keeps the port for a whole frame: every command up to
//   and including a RUN or CLR handshake. This keeps SPK/SPK_PRDC commands from
//   different requesters from interleaving ahead of a RUN. Round-robin fairness
//   applies between frames.
//
// Ports:
//   clk, arstn             clock; asynchronous active-low reset
//   req_valid, req_ready   per-requester valid/ready (one bit per requester)
//   req_cmd                flattened commands, requester i at [i*CMD_WIDTH +: CMD_WIDTH]
//   src_valid, src_ready   command handshake towards network_source
//   src                    command word towards network_source
//   grant_id               current or most recent grantee
//   busy                   FSM state view: 1 = LOCKED, 0 = IDLE
//   timeout                one-cycle pulse when an idle lock is force-released
//
// Handshake: a word transfers on every cycle where valid && ready. A source
//   that holds valid without seeing ready must keep valid and its data stable.
//   Non-granted requesters always see ready low.
//
// Optional feature (macro SOURCE_ARB_TIMEOUT_EN): release the lock after
//   TIMEOUT_CYCLES consecutive locked cycles with the grantee's valid low.
//   When the macro is not defined, the lock is held until RUN/CLR and timeout
//   is tied low.

module source_frame_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int CMD_WIDTH      = 32,
  parameter int OPC_WIDTH      = 3,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int GID_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         clk,
  input  logic                         arstn,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*CMD_WIDTH-1:0] req_cmd,
  output logic                         src_valid,
  input  logic                         src_ready,
  output logic [CMD_WIDTH-1:0]         src,
  output logic [GID_W-1:0]             grant_id,
  output logic                         busy,
  output logic                         timeout
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  localparam logic [OPC_WIDTH-1:0] OPC_RUN = OPC_WIDTH'(1);
  localparam logic [OPC_WIDTH-1:0] OPC_CLR = OPC_WIDTH'(3);

  state_t                 state_q, state_d;
  logic [GID_W-1:0]       grant_id_q, grant_id_d;
  logic [GID_W-1:0]       last_q, last_d;

  logic                   sel_valid;
  logic [CMD_WIDTH-1:0]   sel_cmd;
  logic [OPC_WIDTH-1:0]   sel_opc;
  logic                   sel_term;
  logic                   pick_found;
  logic [GID_W-1:0]       pick_idx;

`ifdef SOURCE_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0]          cnt_q, cnt_d;
  logic                   timeout_q, timeout_d;
`endif

  // Grantee's command lane.
  always_comb begin
    sel_valid = 1'b0;
    sel_cmd   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == GID_W'(i)) begin
        sel_valid = req_valid[i];
        sel_cmd   = req_cmd[i*CMD_WIDTH +: CMD_WIDTH];
      end
    end
  end

  assign sel_opc  = sel_cmd[CMD_WIDTH-1 -: OPC_WIDTH];
  assign sel_term = (sel_opc == OPC_RUN) || (sel_opc == OPC_CLR);

  // Round-robin pick starting after last_q. Indices above last_q come first.
  // The second loop overrides the first. Descending loops leave the lowest
  // index as the winner within each group.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (GID_W'(i) <= last_q)) begin
        pick_found = 1'b1;
        pick_idx   = GID_W'(i);
      end
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (GID_W'(i) > last_q)) begin
        pick_found = 1'b1;
        pick_idx   = GID_W'(i);
      end
    end
  end

  // Next state and outputs.
  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    last_d     = last_q;
    src_valid  = 1'b0;
    src        = '0;
    req_ready  = '0;
    busy       = 1'b0;
`ifdef SOURCE_ARB_TIMEOUT_EN
    cnt_d      = cnt_q;
    timeout_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
`ifdef SOURCE_ARB_TIMEOUT_EN
        cnt_d = '0;
`endif
        if (pick_found) begin
          grant_id_d = pick_idx;
          state_d    = LOCKED;
        end
      end
      LOCKED: begin
        busy      = 1'b1;
        src_valid = sel_valid;
        src       = sel_cmd;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (grant_id_q == GID_W'(i)) req_ready[i] = src_ready;
        end
        if (sel_valid && src_ready && sel_term) begin
          last_d  = grant_id_q;
          state_d = IDLE;
        end
`ifdef SOURCE_ARB_TIMEOUT_EN
        else if (sel_valid) begin
          cnt_d = '0;
        end else if (cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          // This is the TIMEOUT_CYCLES-th idle cycle. Release without
          // injecting any command.
          timeout_d = 1'b1;
          last_d    = grant_id_q;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q    <= IDLE;
      grant_id_q <= '0;
      last_q     <= GID_W'(NUM_REQ - 1);
`ifdef SOURCE_ARB_TIMEOUT_EN
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      last_q     <= last_d;
`ifdef SOURCE_ARB_TIMEOUT_EN
      cnt_q      <= cnt_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  assign grant_id = grant_id_q;

`ifdef SOURCE_ARB_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
  // TIMEOUT_CYCLES only matters when the idle-lock timeout is built in.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

endmodule

// File: tb/tb_source_frame_arbiter.sv
module tb_source_frame_arbiter;
  localparam int NUM_REQ   = 2;
  localparam int CMD_WIDTH = 32;
  localparam int OPC_WIDTH = 3;
  localparam int TO        = 8;
  localparam int GW        = 1;
  localparam int W         = GW + CMD_WIDTH;

  // ---------------- clock / reset ----------------
  logic                         clk = 1'b0;
  logic                         arstn;
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ*CMD_WIDTH-1:0] req_cmd;
  logic                         src_valid;
  logic                         src_ready;
  logic [CMD_WIDTH-1:0]         src;
  logic [GW-1:0]                grant_id;
  logic                         busy;
  logic                         timeout;

  always #5 clk = ~clk;

  source_frame_arbiter #(
    .NUM_REQ(NUM_REQ), .CMD_WIDTH(CMD_WIDTH), .OPC_WIDTH(OPC_WIDTH), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .arstn(arstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .src_valid(src_valid), .src_ready(src_ready), .src(src),
    .grant_id(grant_id), .busy(busy), .timeout(timeout)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- stimulus state ----------------
  logic [CMD_WIDTH:0]  dq [NUM_REQ][$];   // driver queues: {first_of_frame, cmd}
  logic [CMD_WIDTH:0]  mq [NUM_REQ][$];   // frame model input
  logic [W-1:0]        exp_q[$];          // expected {grantee, word} on src
  int  plan_last = NUM_REQ - 1;
  bit  bubble_en = 0;
  bit  rand_ready = 0;
  int  hold_low = 0;
  bit  chk_en = 0;
  int  to_seen = 0;

  // cycle-level expectations of the lock
  bit m_busy, m_to;
  int m_gnt, m_last, m_cnt;

  task automatic model_reset();
    m_busy = 0; m_to = 0; m_gnt = 0; m_last = NUM_REQ - 1; m_cnt = 0;
    plan_last = NUM_REQ - 1;
  endtask

  function automatic logic [CMD_WIDTH-1:0] mk(input int opc, input int idx, input int val);
    return {3'(opc), 13'(idx), 16'(val)};
  endfunction

  function automatic bit is_term(input logic [CMD_WIDTH-1:0] c);
    logic [OPC_WIDTH-1:0] o;
    o = c[CMD_WIDTH-1 -: OPC_WIDTH];
    return (o == 3'd1) || (o == 3'd3);
  endfunction

  task automatic load(input int r, input logic [CMD_WIDTH-1:0] c, input bit first, input bit to_model);
    dq[r].push_back({first, c});
    if (to_model) mq[r].push_back({first, c});
  endtask

  task automatic load_rand_frame(input int r);
    int n, op;
    n = $urandom_range(1, 4);
    for (int k = 0; k < n - 1; k++) begin
      case ($urandom_range(0, 5))
        0: op = 0; 1: op = 2; 2: op = 4; 3: op = 5; 4: op = 6; default: op = 7;
      endcase
      load(r, mk(op, $urandom_range(0, 8191), $urandom_range(0, 65535)), k == 0, 1);
    end
    op = ($urandom_range(0, 1) == 0) ? 1 : 3;
    load(r, mk(op, $urandom_range(0, 8191), $urandom_range(0, 65535)), n == 1, 1);
  endtask

  // Frame-level reference: whole frames leave in round-robin order among
  // requesters with pending frames, starting after the previous owner.
  task automatic plan();
    int r, c;
    logic [CMD_WIDTH:0] w;
    while (mq[0].size() + mq[1].size() > 0) begin
      r = -1;
      for (int k = 1; k <= NUM_REQ; k++) begin
        c = (plan_last + k) % NUM_REQ;
        if (r < 0 && mq[c].size() > 0) r = c;
      end
      do begin
        w = mq[r].pop_front();
        exp_q.push_back({GW'(r), w[CMD_WIDTH-1:0]});
      end while (!is_term(w[CMD_WIDTH-1:0]));
      plan_last = r;
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || dq[0].size() != 0 || dq[1].size() != 0 || m_busy) && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk(name, n < 500, 1'b1);
  endtask

  task automatic wait_exp_le(input int lim, input string name);
    int n;
    n = 0;
    while (exp_q.size() > lim && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(name, n < 200, 1'b1);
  endtask

  // ---------------- driver ----------------
  initial begin : driver
    bit hs [NUM_REQ];
    int bub_run [NUM_REQ];
    bit hold, bub;
    for (int i = 0; i < NUM_REQ; i++) bub_run[i] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NUM_REQ; i++) hs[i] = req_valid[i] && req_ready[i];
      @(posedge clk);
      #1;
      if (!arstn) continue;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (hs[i] && dq[i].size() > 0) void'(dq[i].pop_front());
        if (dq[i].size() > 0) begin
          hold = req_valid[i] && !hs[i];
          bub  = !hold && !dq[i][0][CMD_WIDTH] && bubble_en && bub_run[i] < 2
                 && ($urandom_range(0, 3) == 0);
          bub_run[i] = bub ? bub_run[i] + 1 : 0;
          req_valid[i] = !bub;
          req_cmd[i*CMD_WIDTH +: CMD_WIDTH] = dq[i][0][CMD_WIDTH-1:0];
        end else begin
          req_valid[i] = 1'b0;
        end
      end
      if (hold_low > 0) begin
        src_ready = 1'b0;
        hold_low--;
      end else if (rand_ready) src_ready = ($urandom_range(0, 3) != 0);
      else src_ready = 1'b1;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    logic [CMD_WIDTH-1:0] cur_cmd, prev_src;
    logic [NUM_REQ-1:0]   er;
    logic [W-1:0]         e;
    bit prev_stall, found;
    int c;
    prev_stall = 0;
    prev_src = '0;
    forever begin
      @(negedge clk);
      if (!chk_en) begin
        prev_stall = 0;
        continue;
      end
      cur_cmd = req_cmd[m_gnt*CMD_WIDTH +: CMD_WIDTH];
      chk("busy", busy, m_busy);
      chk("timeout", timeout, m_to);
      chk("grant_id", grant_id, m_gnt);
      er = '0;
      if (m_busy) begin
        er[m_gnt] = src_ready;
        chk("src_valid", src_valid, req_valid[m_gnt]);
        chk("src", src, cur_cmd);
      end else begin
        chk("idle_src_valid", src_valid, 1'b0);
        chk("idle_src", src, '0);
      end
      chk("req_ready", req_ready, er);
      if (prev_stall) begin
        chk("stall_valid", src_valid, 1'b1);
        chk("stall_src", src, prev_src);
      end
      prev_stall = src_valid && !src_ready;
      prev_src   = src;
      if (timeout) to_seen++;
      if (src_valid && src_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_word: got %0h with no word expected at %0t", {grant_id, src}, $time);
        end else begin
          e = exp_q.pop_front();
          chk("sb_word", {grant_id, src}, e);
        end
      end
      // advance the expected lock state to the next cycle
      m_to = 0;
      if (!m_busy) begin
        found = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
          c = (m_last + k) % NUM_REQ;
          if (!found && req_valid[c]) begin
            found = 1;
            m_gnt = c;
          end
        end
        if (found) begin
          m_busy = 1;
          m_cnt = 0;
        end
      end else if (req_valid[m_gnt] && src_ready && is_term(cur_cmd)) begin
        m_last = m_gnt;
        m_busy = 0;
      end
`ifdef SOURCE_ARB_TIMEOUT_EN
      else if (req_valid[m_gnt]) m_cnt = 0;
      else begin
        m_cnt++;
        if (m_cnt == TO) begin
          m_to = 1;
          m_last = m_gnt;
          m_busy = 0;
        end
      end
`endif
    end
  end

  // ---------------- main sequence ----------------
  initial begin : main
    arstn = 1'b0;
    req_valid = '1;
    req_cmd = {$urandom, $urandom};
    src_ready = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_src_valid", src_valid, 1'b0);
    chk("rst_src", src, '0);
    chk("rst_req_ready", req_ready, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_grant", grant_id, '0);
    req_valid = '0;
    arstn = 1'b1;
    chk_en = 1;

    // both valid from reset: req0 frame first, then req1
    load(0, mk(2, 7, 1), 1, 1); load(0, mk(1, 0, 2), 0, 1);
    load(1, mk(2, 9, 3), 1, 1); load(1, mk(1, 0, 4), 0, 1);
    plan();
    wait_drain("both_from_reset");

    // single requester: SPK(1,5), SPK(2,3), RUN(4)
    load(0, mk(2, 1, 5), 1, 1); load(0, mk(2, 2, 3), 0, 1); load(0, mk(1, 0, 4), 0, 1);
    plan();
    wait_drain("single_req0");

    // three frames each, random ready and mid-frame valid drops
    bubble_en = 1; rand_ready = 1;
    for (int f = 0; f < 3; f++) begin
      load_rand_frame(0);
      load_rand_frame(1);
    end
    plan();
    wait_drain("three_frames_each");

    // src_ready held low for 5 cycles mid-frame
    bubble_en = 0; rand_ready = 0;
    for (int r = 0; r < NUM_REQ; r++) begin
      load(r, mk(2, r, 10), 1, 1); load(r, mk(4, r, 11), 0, 1);
      load(r, mk(2, r, 12), 0, 1); load(r, mk(1, r, 13), 0, 1);
    end
    plan();
    wait_exp_le(7, "stall_first_word");
    hold_low = 5;
    wait_drain("stall_mid_frame");

    // req1 NOP, SPK, CLR while req0 waits
    load(1, mk(0, 0, 0), 1, 1); load(1, mk(2, 3, 3), 0, 1); load(1, mk(3, 0, 0), 0, 1);
    plan();
    wait_exp_le(2, "nop_granted");
    load(0, mk(2, 4, 4), 1, 1); load(0, mk(1, 0, 5), 0, 1);
    plan();
    wait_drain("nop_clr_frame");

    // random rounds
    bubble_en = 1; rand_ready = 1;
    for (int rnd = 0; rnd < 8; rnd++) begin
      for (int r = 0; r < NUM_REQ; r++) begin
        int nf;
        nf = $urandom_range(0, 2);
        for (int f = 0; f < nf; f++) load_rand_frame(r);
      end
      plan();
      wait_drain("random_round");
    end

    // grantee sends SPK then drops valid while req1 waits
    bubble_en = 0; rand_ready = 0;
    to_seen = 0;
    load(0, mk(2, 6, 6), 1, 0);
    exp_q.push_back({1'b0, mk(2, 6, 6)});
    wait_exp_le(0, "open_frame_word");
    load(1, mk(2, 7, 7), 1, 0); load(1, mk(1, 0, 7), 0, 0);
    exp_q.push_back({1'b1, mk(2, 7, 7)});
    exp_q.push_back({1'b1, mk(1, 0, 7)});
`ifdef SOURCE_ARB_TIMEOUT_EN
    wait_drain("timeout_release");
    chk("timeout_pulses", to_seen, 1);
`else
    repeat (30) @(negedge clk);
    chk("lock_held_busy", busy, 1'b1);
    chk("lock_held_req1_waits", exp_q.size(), 2);
    load(0, mk(1, 0, 8), 0, 0);
    exp_q.push_front({1'b0, mk(1, 0, 8)});
    wait_drain("lock_released_by_run");
    chk("timeout_pulses", to_seen, 0);
`endif
    plan_last = 1;

    // async reset mid-frame
    load(1, mk(2, 1, 1), 1, 0);
    exp_q.push_back({1'b1, mk(2, 1, 1)});
    wait_exp_le(0, "pre_reset_word");
    chk_en = 0;
    @(negedge clk);
    #2;
    arstn = 1'b0;
    #1;
    chk("async_rst_src_valid", src_valid, 1'b0);
    chk("async_rst_req_ready", req_ready, '0);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_grant", grant_id, '0);
    dq[0].delete(); dq[1].delete();
    req_valid = '0;
    @(negedge clk);
    arstn = 1'b1;
    model_reset();
    chk_en = 1;

    // after reset requester 0 has priority again
    load(1, mk(2, 2, 2), 1, 1); load(1, mk(3, 0, 0), 0, 1);
    load(0, mk(2, 3, 3), 1, 1); load(0, mk(1, 0, 1), 0, 1);
    plan();
    wait_drain("post_reset_priority");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
